// File: rtl/arbiter_wrr.sv
// Work-conserving weighted round-robin arbiter: a grantee keeps the grant for up
// to weight[i] acknowledged beats, then rotation moves on from its index.
module arbiter_wrr #(
  parameter  int VECTOR_IN = 8,
  parameter  int WEIGHT_W  = 4,
  localparam int ID_W      = $clog2(VECTOR_IN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [VECTOR_IN-1:0]          request_vector,
  input  logic [VECTOR_IN*WEIGHT_W-1:0] weight,
  input  logic                          ack,
  output logic [VECTOR_IN-1:0]          grant,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id
);

  localparam int SUM_W = ID_W + 1;

  // Registered state; grant_id_q doubles as the current grantee index.
  logic [VECTOR_IN-1:0] grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [ID_W-1:0]      last_q, last_d;

  logic [WEIGHT_W-1:0]  weight_arr [VECTOR_IN];
  logic [WEIGHT_W-1:0]  win_weight;
  logic [SUM_W-1:0]     search_idx;
  logic [ID_W-1:0]      win_id;
  logic                 found;
  logic                 hold;

  always_comb begin
    for (int i = 0; i < VECTOR_IN; i++) begin
      weight_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Rotating search starting just after last_q; last_q itself is tried last.
  always_comb begin
    found      = 1'b0;
    win_id     = '0;
    search_idx = '0;
    for (int off = 1; off <= VECTOR_IN; off++) begin
      search_idx = {1'b0, last_q} + SUM_W'(off);
      if (search_idx >= SUM_W'(VECTOR_IN)) begin
        search_idx = search_idx - SUM_W'(VECTOR_IN);
      end
      if (!found && request_vector[search_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = search_idx[ID_W-1:0];
      end
    end
  end

  assign win_weight = weight_arr[win_id];

  // The final acknowledged beat releases the grant in the same edge, so the
  // next grantee appears without a bubble.
  assign hold = grant_valid_q && request_vector[grant_id_q] &&
                !(ack && (credit_q == WEIGHT_W'(1)));

  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    credit_d      = credit_q;
    last_d        = last_q;
    if (hold) begin
      if (ack) begin
        credit_d = credit_q - WEIGHT_W'(1);
      end
    end else if (found) begin
      grant_d         = '0;
      grant_d[win_id] = 1'b1;
      grant_valid_d   = 1'b1;
      grant_id_d      = win_id;
      credit_d        = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
      last_d          = win_id;
    end else begin
      grant_d       = '0;
      grant_valid_d = 1'b0;
      grant_id_d    = '0;
      credit_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      credit_q      <= '0;
      last_q        <= ID_W'(VECTOR_IN - 1);
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      credit_q      <= credit_d;
      last_q        <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: a vector table of {weights, requests, ack,
// expected grant} plus hand-written reset sequences.
module tb_arbiter_wrr;

  localparam int N  = 8;
  localparam int WW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    request_vector;
  logic [N*WW-1:0] weight;
  logic            ack;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [2:0]      grant_id;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] wgt;
    logic [7:0]  req;
    logic        ack;
    logic        exp_valid;
    logic [2:0]  exp_id;
    string       name;
  } vec_t;

  vec_t vecs[$];

  arbiter_wrr #(.VECTOR_IN(N), .WEIGHT_W(WW)) dut (
    .clk            (clk),
    .reset          (reset),
    .request_vector (request_vector),
    .weight         (weight),
    .ack            (ack),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic exp_valid, input logic [2:0] exp_id);
    logic [7:0] exp_grant;
    exp_grant = 8'h00;
    if (exp_valid) exp_grant[exp_id] = 1'b1;
    checks++;
    if (grant !== exp_grant || grant_valid !== exp_valid || grant_id !== exp_id) begin
      errors++;
      $display("FAIL %s: got grant=%02h valid=%0b id=%0d, want grant=%02h valid=%0b id=%0d",
               name, grant, grant_valid, grant_id, exp_grant, exp_valid, exp_id);
    end
  endtask

  function automatic void add(input logic [31:0] w, input logic [7:0] r, input logic a,
                              input logic v, input logic [2:0] id, input string nm);
    vec_t t;
    t.wgt = w; t.req = r; t.ack = a; t.exp_valid = v; t.exp_id = id; t.name = nm;
    vecs.push_back(t);
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // All weights 1, full rotation with an ack every beat.
    for (int i = 1; i <= 8; i++) add(32'h11111111, 8'hFF, 1'b1, 1'b1, 3'(i % 8), "rotate");
    add(32'h11111111, 8'hFF, 1'b1, 1'b1, 3'd1, "rotate_wrap");
    // weight[0]=2, weight[1]=1.
    add(32'h00000012, 8'h03, 1'b1, 1'b1, 3'd0, "wrr_a");
    add(32'h00000012, 8'h03, 1'b1, 1'b1, 3'd0, "wrr_b");
    add(32'h00000012, 8'h03, 1'b1, 1'b1, 3'd1, "wrr_c");
    add(32'h00000012, 8'h03, 1'b1, 1'b1, 3'd0, "wrr_d");
    add(32'h00000012, 8'h03, 1'b1, 1'b1, 3'd0, "wrr_e");
    add(32'h00000012, 8'h03, 1'b1, 1'b1, 3'd1, "wrr_f");
    // Lone requester 2 with weight 3 is regranted back-to-back.
    for (int i = 0; i < 5; i++) add(32'h00000300, 8'h04, 1'b1, 1'b1, 3'd2, "solo");
    add(32'h00000300, 8'h0C, 1'b1, 1'b1, 3'd2, "solo_last_beat");
    add(32'h00000300, 8'h0C, 1'b1, 1'b1, 3'd3, "handover_w0");
    add(32'h00000300, 8'h0C, 1'b1, 1'b1, 3'd2, "back_to_2");
    add(32'h00000300, 8'h0C, 1'b0, 1'b1, 3'd2, "hold_no_ack");
    add(32'h00000300, 8'h08, 1'b0, 1'b1, 3'd3, "drop_req");
    add(32'h00000300, 8'h00, 1'b0, 1'b0, 3'd0, "idle");
    add(32'h00000300, 8'h00, 1'b1, 1'b0, 3'd0, "idle_ack");
    add(32'h00000300, 8'h18, 1'b0, 1'b1, 3'd4, "last_kept");
    // weight[1]=4; requester 1 drops after one ack, later gets fresh credit.
    add(32'h00000040, 8'h0A, 1'b0, 1'b1, 3'd1, "w4_grant");
    add(32'h00000040, 8'h0A, 1'b1, 1'b1, 3'd1, "w4_beat1");
    add(32'h00000040, 8'h08, 1'b0, 1'b1, 3'd3, "w4_drop");
    add(32'h00000040, 8'h0A, 1'b1, 1'b1, 3'd1, "w4_regrant");
    add(32'h00000040, 8'h0A, 1'b1, 1'b1, 3'd1, "w4_c3");
    add(32'h00000040, 8'h0A, 1'b1, 1'b1, 3'd1, "w4_c2");
    add(32'h00000040, 8'h0A, 1'b1, 1'b1, 3'd1, "w4_c1");
    add(32'h00000040, 8'h0A, 1'b1, 1'b1, 3'd3, "w4_release");
    // Set up requester 5 mid-burst with credit 2.
    add(32'h00300000, 8'h20, 1'b0, 1'b1, 3'd5, "g5");
    add(32'h00300000, 8'h20, 1'b1, 1'b1, 3'd5, "g5_c2");

    // Reset with all requests up and no ack.
    reset          = 1'b0;
    request_vector = 8'hFF;
    weight         = 32'h11111111;
    ack            = 1'b0;
    tick();
    check("reset_state", 1'b0, 3'd0);
    tick();
    check("reset_hold", 1'b0, 3'd0);
    reset = 1'b1;
    tick();
    check("first_grant", 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_without_ack", 1'b1, 3'd0);
    end

    foreach (vecs[i]) begin
      weight         = vecs[i].wgt;
      request_vector = vecs[i].req;
      ack            = vecs[i].ack;
      tick();
      check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_id);
    end

    // Asynchronous reset in the middle of a burst.
    ack = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_reset_drop", 1'b0, 3'd0);
    request_vector = 8'h21;
    tick();
    check("reset_held", 1'b0, 3'd0);
    reset = 1'b1;
    tick();
    check("post_reset_pointer", 1'b1, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
